cfir_decim: RTL and testbench

- Decimating complex FIR channel filter, directly downstream of the IQ reader stage.
- Pops quantized I and Q samples from two parallel FWFT FIFOs and keeps a TAPS-deep complex delay line.
- Every DECIM input samples, runs a sequential complex multiply-accumulate over all taps, then pushes the filtered I/Q pair into two output FIFOs feeding demodulation.

---
 rtl/cfir_decim_if.sv | 39 +++
 rtl/cfir_decim.sv | 152 +++++++++++++++
 tb/tb_cfir_decim.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cfir_decim_if.sv
// cfir_decim_if: every handshake and bus signal of the decimating complex FIR.
//   Input side : i_*/q_* pop strobes, empty flags and FWFT data of the I/Q FIFOs
//   Config side: coef_wr_en, coef_addr, coef_re, coef_im, busy
//   Output side: y_i_*/y_q_* push strobes, full flags and filtered data
// Modports: master = filter core, slave = surrounding FIFOs / host.
interface cfir_decim_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_rd_en;
  logic              i_empty;
  logic [DATA_W-1:0] i_dout;
  logic              q_rd_en;
  logic              q_empty;
  logic [DATA_W-1:0] q_dout;
  logic              coef_wr_en;
  logic [ADDR_W-1:0] coef_addr;
  logic [DATA_W-1:0] coef_re;
  logic [DATA_W-1:0] coef_im;
  logic              busy;
  logic              y_i_wr_en;
  logic              y_i_full;
  logic [DATA_W-1:0] y_i_din;
  logic              y_q_wr_en;
  logic              y_q_full;
  logic [DATA_W-1:0] y_q_din;

  modport master (
    output i_rd_en, q_rd_en, busy, y_i_wr_en, y_i_din, y_q_wr_en, y_q_din,
    input  i_empty, i_dout, q_empty, q_dout, coef_wr_en, coef_addr,
           coef_re, coef_im, y_i_full, y_q_full
  );

  modport slave (
    input  i_rd_en, q_rd_en, busy, y_i_wr_en, y_i_din, y_q_wr_en, y_q_din,
    output i_empty, i_dout, q_empty, q_dout, coef_wr_en, coef_addr,
           coef_re, coef_im, y_i_full, y_q_full
  );
endinterface

// File: rtl/cfir_decim.sv
// cfir_decim: decimating complex FIR channel filter.
// Pops I/Q pairs from two FWFT FIFOs into a TAPS-deep complex delay line; every
// DECIM samples runs one complex MAC per cycle over all taps, then pushes the
// filtered I/Q pair into two output FIFOs.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    cfir_decim_if.master (input FIFOs, coefficient writes, busy, output FIFOs)
// Build option: define CFIR_SAT_EN for DATA_W+8 bit accumulators that saturate
// to DATA_W on output; otherwise accumulators are DATA_W wide and wrap.
//
// state  | meaning
// S_LOAD | idle / collecting DECIM input samples, coefficient writes allowed
// S_MAC  | one complex tap per cycle, tap_idx 0..TAPS-1
// S_OUT  | waiting for room in both output FIFOs, then push
module cfir_decim #(
  parameter int TAPS   = 20,
  parameter int DECIM  = 1,
  parameter int BITS   = 10,
  parameter int DATA_W = 32
) (
  input logic         clock,
  input logic         reset,
  cfir_decim_if.master bus
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW = 2 * DATA_W;
`ifdef CFIR_SAT_EN
  localparam int AccW = DATA_W + 8;
`else
  localparam int AccW = DATA_W;
`endif
  // Bias that turns the arithmetic shift into truncation toward zero.
  localparam logic [PW-1:0] RND = {{(PW-BITS){1'b0}}, {BITS{1'b1}}};

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_t;

  state_t                   r_state, w_state_nxt;
  logic                     w_pop, w_push;
  logic [CW-1:0]            r_sample_cnt;
  logic [AW-1:0]            r_tap_idx;
  logic signed [AccW-1:0]   r_acc_i, r_acc_q;
  logic signed [DATA_W-1:0] r_xi  [TAPS];
  logic signed [DATA_W-1:0] r_xq  [TAPS];
  logic signed [DATA_W-1:0] r_cre [TAPS];
  logic signed [DATA_W-1:0] r_cim [TAPS];
  logic signed [PW-1:0]     w_cr, w_ci, w_xi, w_xq, w_re, w_im;
  logic signed [DATA_W-1:0] w_out_i, w_out_q;

  function automatic logic signed [DATA_W-1:0] deq(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t;
    t = v[PW-1] ? v + $signed(RND) : v;
    return DATA_W'(t >>> BITS);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_LOAD: if (!bus.i_empty && !bus.q_empty) begin
        w_pop = 1'b1;
        if (r_sample_cnt == CW'(DECIM - 1)) w_state_nxt = S_MAC;
      end
      S_MAC:  if (r_tap_idx == AW'(TAPS - 1)) w_state_nxt = S_OUT;
      S_OUT:  if (!bus.y_i_full && !bus.y_q_full) begin
        w_push      = 1'b1;
        w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Sign-extend to product width so the 2*DATA_W products and sums are exact.
  assign w_cr = PW'(r_cre[r_tap_idx]);
  assign w_ci = PW'(r_cim[r_tap_idx]);
  assign w_xi = PW'(r_xi[r_tap_idx]);
  assign w_xq = PW'(r_xq[r_tap_idx]);
  assign w_re = w_cr * w_xi - w_ci * w_xq;
  assign w_im = w_ci * w_xi + w_cr * w_xq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sample_cnt <= '0;
      r_tap_idx    <= '0;
      r_acc_i      <= '0;
      r_acc_q      <= '0;
      for (int k = 0; k < TAPS; k++) begin
        r_xi[k] <= '0;
        r_xq[k] <= '0;
      end
    end else begin
      if (w_pop) begin
        for (int k = TAPS - 1; k > 0; k--) begin
          r_xi[k] <= r_xi[k-1];
          r_xq[k] <= r_xq[k-1];
        end
        r_xi[0]      <= bus.i_dout;
        r_xq[0]      <= bus.q_dout;
        r_sample_cnt <= (r_sample_cnt == CW'(DECIM - 1)) ? '0 : r_sample_cnt + 1'b1;
      end
      if (r_state == S_MAC) begin
        r_acc_i   <= r_acc_i + AccW'(deq(w_re));
        r_acc_q   <= r_acc_q + AccW'(deq(w_im));
        r_tap_idx <= (r_tap_idx == AW'(TAPS - 1)) ? '0 : r_tap_idx + 1'b1;
      end
      if (w_push) begin
        r_acc_i <= '0;
        r_acc_q <= '0;
      end
    end
  end

  // Coefficient table has no reset; host loads it before use.
  always_ff @(posedge clock) begin
    if (bus.coef_wr_en && r_state == S_LOAD) begin
      r_cre[bus.coef_addr] <= bus.coef_re;
      r_cim[bus.coef_addr] <= bus.coef_im;
    end
  end

`ifdef CFIR_SAT_EN
  localparam logic signed [AccW-1:0] SAT_MAX = AccW'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [AccW-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [AccW-1:0] a);
    if (a > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (a < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return a[DATA_W-1:0];
  endfunction

  assign w_out_i = sat(r_acc_i);
  assign w_out_q = sat(r_acc_q);
`else
  assign w_out_i = r_acc_i;
  assign w_out_q = r_acc_q;
`endif

  assign bus.i_rd_en   = w_pop;
  assign bus.q_rd_en   = w_pop;
  assign bus.busy      = (r_state != S_LOAD);
  assign bus.y_i_wr_en = w_push;
  assign bus.y_q_wr_en = w_push;
  assign bus.y_i_din   = w_push ? w_out_i : '0;
  assign bus.y_q_din   = w_push ? w_out_q : '0;
endmodule

// File: tb/tb_cfir_decim.sv
module tb_cfir_decim;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int NV = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cfir_decim_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  cfir_decim_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  cfir_decim #(.TAPS(4), .DECIM(1), .BITS(10), .DATA_W(DW)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a));
  cfir_decim #(.TAPS(4), .DECIM(4), .BITS(10), .DATA_W(DW)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b));

  typedef struct { int cre; int cim; int xi; int xq; int ei; int eq; } vec_t;
  vec_t tbl [NV];

  int n_vec = 0, n_err = 0;
  int cyc = 0, pop_cyc = 0, proto_bad = 0;
  int na = 0, nb = 0;
  int qa_i[$], qa_q[$], qa_c[$], qb_i[$], qb_q[$], qb_c[$];

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) if (!reset) begin
    if (bus_a.y_i_wr_en || bus_a.y_q_wr_en) begin
      if (bus_a.y_i_wr_en != bus_a.y_q_wr_en) proto_bad++;
      qa_i.push_back($signed(bus_a.y_i_din)); qa_q.push_back($signed(bus_a.y_q_din));
      qa_c.push_back(cyc); na++;
    end else if (bus_a.y_i_din != 0 || bus_a.y_q_din != 0) proto_bad++;
    if (bus_b.y_i_wr_en || bus_b.y_q_wr_en) begin
      if (bus_b.y_i_wr_en != bus_b.y_q_wr_en) proto_bad++;
      qb_i.push_back($signed(bus_b.y_i_din)); qb_q.push_back($signed(bus_b.y_q_din));
      qb_c.push_back(cyc); nb++;
    end else if (bus_b.y_i_din != 0 || bus_b.y_q_din != 0) proto_bad++;
    if (bus_a.i_rd_en != bus_a.q_rd_en || bus_b.i_rd_en != bus_b.q_rd_en) proto_bad++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wr_coef(input int sel, input int addr, input int re, input int im);
    if (sel == 0) begin
      bus_a.coef_wr_en = 1'b1; bus_a.coef_addr = addr[AW-1:0];
      bus_a.coef_re = re; bus_a.coef_im = im;
    end else begin
      bus_b.coef_wr_en = 1'b1; bus_b.coef_addr = addr[AW-1:0];
      bus_b.coef_re = re; bus_b.coef_im = im;
    end
    tick();
    bus_a.coef_wr_en = 1'b0;
    bus_b.coef_wr_en = 1'b0;
  endtask

  task automatic offer(input int sel, input int xi, input int xq);
    if (sel == 0) begin
      bus_a.i_dout = xi; bus_a.q_dout = xq; bus_a.i_empty = 1'b0; bus_a.q_empty = 1'b0;
    end else begin
      bus_b.i_dout = xi; bus_b.q_dout = xq; bus_b.i_empty = 1'b0; bus_b.q_empty = 1'b0;
    end
  endtask

  task automatic await_pop(input int sel);
    bit done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clock);
      if ((sel == 0 && bus_a.i_rd_en) || (sel == 1 && bus_b.i_rd_en)) begin
        done = 1'b1;
        pop_cyc = cyc;
      end
    end
    tick();
    bus_a.i_empty = 1'b1; bus_a.q_empty = 1'b1;
    bus_b.i_empty = 1'b1; bus_b.q_empty = 1'b1;
    if (!done) check("pop_timeout", done, 1);
  endtask

  task automatic push(input int sel, input int xi, input int xq);
    offer(sel, xi, xq);
    await_pop(sel);
  endtask

  task automatic wait_out(input int sel, input string name, input int ei, input int eq,
                          output int lat);
    bit ok = 1'b0;
    int gi = 0, gq = 0, gc = 0;
    lat = -1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clock);
      #1;
      if (sel == 0 && qa_i.size() > 0) begin
        ok = 1'b1; gi = qa_i.pop_front(); gq = qa_q.pop_front(); gc = qa_c.pop_front();
      end else if (sel == 1 && qb_i.size() > 0) begin
        ok = 1'b1; gi = qb_i.pop_front(); gq = qb_q.pop_front(); gc = qb_c.pop_front();
      end
    end
    if (!ok) check({name, "_timeout"}, ok, 1);
    else begin
      check({name, "_i"}, gi, ei);
      check({name, "_q"}, gq, eq);
      lat = gc - pop_cyc;
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bad, n0;
    tbl[0] = '{1024, 0, 5000, -3000, 5000, -3000};
    tbl[1] = '{0, 1024, 100, 200, -200, 100};
    tbl[2] = '{512, 0, -3, 7, -1, 3};
    tbl[3] = '{-1024, 0, 123, -456, -123, 456};
    tbl[4] = '{512, 512, 10, -6, 8, 2};
    tbl[5] = '{0, -512, 5, 3, 1, -2};
    tbl[6] = '{2048, 0, 1000000, -1000000, 2000000, -2000000};

    bus_a.i_empty = 1'b1; bus_a.q_empty = 1'b1; bus_a.i_dout = '0; bus_a.q_dout = '0;
    bus_a.coef_wr_en = 1'b0; bus_a.coef_addr = '0; bus_a.coef_re = '0; bus_a.coef_im = '0;
    bus_a.y_i_full = 1'b0; bus_a.y_q_full = 1'b0;
    bus_b.i_empty = 1'b1; bus_b.q_empty = 1'b1; bus_b.i_dout = '0; bus_b.q_dout = '0;
    bus_b.coef_wr_en = 1'b0; bus_b.coef_addr = '0; bus_b.coef_re = '0; bus_b.coef_im = '0;
    bus_b.y_i_full = 1'b0; bus_b.y_q_full = 1'b0;

    reset = 1'b1;
    tick(); tick();
    @(negedge clock);
    check("rst_busy_a", bus_a.busy, 0);
    check("rst_busy_b", bus_b.busy, 0);
    check("rst_rd_en_a", bus_a.i_rd_en, 0);
    check("rst_wr_en_a", bus_a.y_i_wr_en | bus_a.y_q_wr_en, 0);
    check("rst_din_a", bus_a.y_i_din | bus_a.y_q_din, 0);
    tick();
    reset = 1'b0;
    tick();

    // Single-tap vectors: taps 1..3 zero so only the newest sample matters.
    for (int k = 0; k < 4; k++) wr_coef(0, k, 0, 0);
    for (int v = 0; v < NV; v++) begin
      wr_coef(0, 0, tbl[v].cre, tbl[v].cim);
      push(0, tbl[v].xi, tbl[v].xq);
      wait_out(0, $sformatf("vec%0d", v), tbl[v].ei, tbl[v].eq, lat);
      check($sformatf("vec%0d_latency", v), lat, 5);
    end

    // Decimation by 4 with four taps of 0.25.
    for (int k = 0; k < 4; k++) wr_coef(1, k, 256, 0);
    push(1, 4, 0); push(1, 8, 0); push(1, 12, 0);
    repeat (20) tick();
    check("dec_partial_none", nb, 0);
    push(1, 16, 0);
    wait_out(1, "dec_out1", 10, 0, lat);
    push(1, 20, 0); push(1, 24, 0); push(1, 28, 0); push(1, 32, 0);
    wait_out(1, "dec_out2", 26, 0, lat);
    repeat (20) tick();
    check("dec_count", nb, 2);

    // Backpressure on the Q output FIFO.
    wr_coef(0, 0, 1024, 0);
    bus_a.y_q_full = 1'b1;
    n0 = na;
    push(0, 7, -9);
    repeat (6) tick();
    offer(0, 11, 13);
    bad = 0;
    repeat (50) begin
      @(negedge clock);
      if (bus_a.y_i_wr_en || bus_a.y_q_wr_en || bus_a.i_rd_en || !bus_a.busy) bad++;
    end
    check("bp_hold_bad_cycles", bad, 0);
    check("bp_no_push", na - n0, 0);
    tick();
    bus_a.y_q_full = 1'b0;
    wait_out(0, "bp_release", 7, -9, lat);
    await_pop(0);
    wait_out(0, "bp_next", 11, 13, lat);
    check("bp_push_count", na - n0, 2);

    // Reset during S_MAC discards the pass and the delay line.
    wr_coef(0, 1, 1024, 0);
    push(0, 50, 60);
    tick(); tick();
    n0 = na;
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("rstmac_busy", bus_a.busy, 0);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("rstmac_no_push", na - n0, 0);
    push(0, -77, 33);
    wait_out(0, "rstmac_fresh", -77, 33, lat);

    // Write while busy is dropped: tap 1 keeps 1.0.
    push(0, 5, 6);
    bus_a.coef_wr_en = 1'b1; bus_a.coef_addr = 2'd1; bus_a.coef_re = '0; bus_a.coef_im = '0;
    tick(); tick();
    bus_a.coef_wr_en = 1'b0;
    wait_out(0, "busy_wr_ignored", -72, 39, lat);

    // Write in the same cycle as a pop lands and is used by that pass.
    bus_a.coef_wr_en = 1'b1; bus_a.coef_addr = 2'd1; bus_a.coef_re = '0; bus_a.coef_im = '0;
    push(0, 9, 9);
    bus_a.coef_wr_en = 1'b0;
    wait_out(0, "wr_with_pop", 9, 9, lat);

    repeat (5) tick();
    check("protocol_violations", proto_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
